if_id_reg: RTL and testbench
============================

IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 The block SHALL have the following ports (name  direction  width  meaning):
  clk        input   1   single clock; all state updates on its rising edge
  reset      input   1   synchronous, active-low reset
  pc_in      input   32  PC register output, i.e. the address of the fetched instruction
  instr_in   input   32  instruction memory read data for pc_in
  hold       input   1   load-use hazard stall request
  hold1      input   1   second stall source (multi-cycle/structural)
  flush      input   1   taken branch/jump; discard the fetched instruction
  pc_out     output  32  registered PC for the decode stage
  pc4_out    output  32  pc_out + 4
  instr_out  output  32  registered instruction for the decode stage
  valid_out  output  1   1 = instr_out is a real instruction; 0 = bubble
  state_out  output  2   current FSM state
  stall_cnt  output  32  cycles spent not loading because of stalls
  bubble_cnt output  32  bubbles inserted by flush
REQ-002 The design SHALL use one clock; reset is synchronous and active-low.

Function
REQ-003 FSM states SHALL be RUN=2'b00, HOLD_LAST=2'b01 and HOLD_TWO=2'b11, so the stall timing matches the PC register's stall sequencing.
REQ-004 In RUN with flush=0, hold=0 and hold1=0, the block SHALL load pc_in and instr_in, set valid_out=1 and stay in RUN.
REQ-005 In RUN with flush=0 and exactly one of hold or hold1 set, the block SHALL keep all registers and go to HOLD_LAST.
REQ-006 In RUN with flush=0 and both hold and hold1 set, the block SHALL keep all registers and go to HOLD_TWO.
REQ-007 In HOLD_TWO with flush=0, the block SHALL keep all registers, ignore hold and hold1, and go to HOLD_LAST.
REQ-008 In HOLD_LAST with flush=0, the block SHALL load pc_in and instr_in, set valid_out=1, ignore hold and hold1, and go to RUN.
REQ-009 When flush=1 in any state, flush SHALL take priority over hold and hold1.
REQ-010 On flush, the block SHALL load instr_out=NOP (32'h0000_0000), keep pc_out, set valid_out=0 and go to RUN.
REQ-011 pc4_out SHALL be pc_out + 32'd4 computed modulo 2^32, so 32'hFFFF_FFFC gives 32'h0000_0000.
REQ-012 The load latency SHALL be one cycle: inputs sampled at edge N appear on the outputs after edge N.
REQ-013 state_out SHALL always equal the current FSM state register.

Reset
REQ-014 With reset=0 at a rising edge, the block SHALL clear pc_out, instr_out and valid_out to 0.
REQ-015 On the same reset edge, pc4_out SHALL become 32'h0000_0004, state SHALL become RUN, and both counters SHALL become 0.
REQ-016 Reset SHALL override flush, hold and hold1, including in the middle of HOLD_TWO or HOLD_LAST.

Configuration
REQ-017 With IFID_PERF_EN defined, stall_cnt SHALL increment in every cycle with no load and no flush.
REQ-018 With IFID_PERF_EN defined, bubble_cnt SHALL increment on every flush cycle.
REQ-019 Both counters SHALL saturate at 32'hFFFF_FFFF.
REQ-020 Without IFID_PERF_EN, stall_cnt and bubble_cnt SHALL be tied to 0, no counter flops SHALL be generated, and the port list SHALL be unchanged.

Structure
REQ-021 The shared package cpu_pkg SHALL hold the NOP constant, the PC increment (4) and the ifid_state_t encoding (RUN, HOLD_LAST, HOLD_TWO).
REQ-022 The counters SHALL be one sub-module, ifid_perf_cnt (saturating 32-bit counter with enable), instantiated twice and only under IFID_PERF_EN.

Verification
REQ-023 Reset release, then pc_in=0x100 and instr_in=0x2002_0005 with no stall -> after next edge: pc_out=0x100, pc4_out=0x104, valid_out=1, state RUN.
REQ-024 hold=1 for one cycle, with pc_in held at 0x104 by the PC -> exactly one edge without a load (state 01), then pc_out=0x104 is loaded; stall_cnt=1 when perf is enabled.
REQ-025 hold=1 and hold1=1 for one cycle -> states 11 then 01 with no loads, load on the third edge; stall_cnt=2.
REQ-026 flush=1 together with hold=1 in RUN -> instr_out=0, valid_out=0, state RUN, bubble_cnt=1, stall_cnt unchanged.
REQ-027 reset=0 asserted while in HOLD_TWO -> next edge: all outputs 0 except pc4_out=4, state RUN; with reset held, no load happens regardless of hold or flush.
REQ-028 pc_in=0xFFFF_FFFC loaded -> pc4_out=0x0000_0000; build without IFID_PERF_EN -> stall_cnt and bubble_cnt stay 0 throughout.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: NOP encoding, PC increment and the
// IF/ID stall-state encoding (kept aligned with the PC register's sequencing).
package cpu_pkg;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    HOLD_LAST = 2'b01,
    HOLD_TWO  = 2'b11
  } ifid_state_t;

endpackage

// File: rtl/ifid_perf_cnt.sv
// Saturating 32-bit event counter with enable and synchronous active-low reset.
module ifid_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] count
);

  // Count enabled cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset)
      count <= '0;
    else if (en && (count != '1))
      count <= count + 32'd1;
  end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with two-source stall sequencing and flush.
// Optional stall/bubble performance counters are built when IFID_PERF_EN
// is defined; otherwise the counter outputs are tied to zero.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        hold,
  input  logic        hold1,
  input  logic        flush,
  output logic [31:0] pc_out,
  output logic [31:0] pc4_out,
  output logic [31:0] instr_out,
  output logic        valid_out,
  output logic [1:0]  state_out,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt
);

  ifid_state_t state;

  // Pipeline register and stall FSM; flush outranks both stall sources.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RUN;
      pc_out    <= '0;
      instr_out <= '0;
      valid_out <= 1'b0;
    end else if (flush) begin
      instr_out <= NOP;
      valid_out <= 1'b0;
      state     <= RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (!hold && !hold1) begin
            pc_out    <= pc_in;
            instr_out <= instr_in;
            valid_out <= 1'b1;
          end else if (hold && hold1) begin
            state <= HOLD_TWO;
          end else begin
            state <= HOLD_LAST;
          end
        end
        HOLD_TWO: state <= HOLD_LAST;
        HOLD_LAST: begin
          pc_out    <= pc_in;
          instr_out <= instr_in;
          valid_out <= 1'b1;
          state     <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign pc4_out   = pc_out + PC_INC;
  assign state_out = state;

`ifdef IFID_PERF_EN
  logic load_c;
  logic stall_en;

  // Decode the same load decision as the FSM to drive the stall counter.
  always_comb begin
    load_c   = !flush && (((state == RUN) && !hold && !hold1) || (state == HOLD_LAST));
    stall_en = !flush && !load_c;
  end

  ifid_perf_cnt u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (stall_en),
    .count (stall_cnt)
  );

  ifid_perf_cnt u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (flush),
    .count (bubble_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: a cycle-level model tracks remaining
// stall cycles and checks every output each cycle; directed steps add
// hand-computed literal expectations.
module tb_if_id_reg;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic        hold;
  logic        hold1;
  logic        flush;
  logic [31:0] pc_out;
  logic [31:0] pc4_out;
  logic [31:0] instr_out;
  logic        valid_out;
  logic [1:0]  state_out;
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;

  int unsigned n_checks;
  int unsigned n_fails;

`ifdef IFID_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  if_id_reg dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc_in),
    .instr_in   (instr_in),
    .hold       (hold),
    .hold1      (hold1),
    .flush      (flush),
    .pc_out     (pc_out),
    .pc4_out    (pc4_out),
    .instr_out  (instr_out),
    .valid_out  (valid_out),
    .state_out  (state_out),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending = number of further edges before the next load
  // (0 = free running, 1 = load on next edge, 2 = one more idle edge first).
  logic [31:0] m_pc, m_instr, m_stall, m_bub;
  logic        m_valid;
  int unsigned pending;
  bit          m_known;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  initial m_known = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_pc = 0; m_instr = 0; m_valid = 0; pending = 0;
      m_stall = 0; m_bub = 0; m_known = 1'b1;
    end else if (m_known) begin
      if (flush) begin
        m_instr = 0; m_valid = 0; pending = 0;
        m_bub = sat_inc(m_bub);
      end else if (pending == 1 || (pending == 0 && !hold && !hold1)) begin
        m_pc = pc_in; m_instr = instr_in; m_valid = 1; pending = 0;
      end else begin
        pending = (pending == 2) ? 1 : int'(hold) + int'(hold1);
        m_stall = sat_inc(m_stall);
      end
    end
    #1;
    if (m_known) begin
      chk("pc_out", pc_out, m_pc);
      chk("pc4_out", pc4_out, m_pc + 32'd4);
      chk("instr_out", instr_out, m_instr);
      chk("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
      chk("state_out", {30'd0, state_out}, (pending == 0) ? 32'd0 : (pending == 1) ? 32'd1 : 32'd3);
      chk("stall_cnt", stall_cnt, PERF ? m_stall : 32'd0);
      chk("bubble_cnt", bubble_cnt, PERF ? m_bub : 32'd0);
    end
  end

  task automatic step(input logic rst, input logic [31:0] pc, input logic [31:0] ins,
                      input logic h, input logic h1, input logic f);
    reset = rst; pc_in = pc; instr_in = ins; hold = h; hold1 = h1; flush = f;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fails = 0;
    reset = 1'b0; pc_in = '0; instr_in = '0; hold = 0; hold1 = 0; flush = 0;
    @(negedge clk);
    step(0, 32'h55, 32'h66, 1, 1, 1);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_pc4", pc4_out, 32'h4);
    chk("rst_state", {30'd0, state_out}, 32'd0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);

    step(1, 32'h100, 32'h2002_0005, 0, 0, 0);
    chk("ld_pc", pc_out, 32'h100);
    chk("ld_pc4", pc4_out, 32'h104);
    chk("ld_instr", instr_out, 32'h2002_0005);
    chk("ld_valid", {31'd0, valid_out}, 32'd1);

    step(1, 32'h104, 32'h11, 1, 0, 0);
    chk("h1_state", {30'd0, state_out}, 32'd1);
    chk("h1_pc", pc_out, 32'h100);
    step(1, 32'h104, 32'h11, 0, 0, 0);
    chk("h1_load", pc_out, 32'h104);
    chk("h1_stall", stall_cnt, PERF ? 32'd1 : 32'd0);

    step(1, 32'h108, 32'h22, 1, 1, 0);
    chk("h2_state_a", {30'd0, state_out}, 32'd3);
    step(1, 32'h108, 32'h22, 1, 0, 0);
    chk("h2_state_b", {30'd0, state_out}, 32'd1);
    chk("h2_noload", pc_out, 32'h104);
    step(1, 32'h108, 32'h22, 1, 1, 0);
    chk("h2_load", pc_out, 32'h108);
    chk("h2_stall", stall_cnt, PERF ? 32'd3 : 32'd0);

    step(1, 32'h10C, 32'h33, 1, 0, 1);
    chk("fl_instr", instr_out, 32'h0);
    chk("fl_valid", {31'd0, valid_out}, 32'd0);
    chk("fl_pc", pc_out, 32'h108);
    chk("fl_bub", bubble_cnt, PERF ? 32'd1 : 32'd0);
    chk("fl_stall", stall_cnt, PERF ? 32'd3 : 32'd0);

    // flush in HOLD_LAST and in HOLD_TWO
    step(1, 32'h10C, 32'h33, 0, 1, 0);
    step(1, 32'h10C, 32'h33, 0, 0, 1);
    chk("flhl_state", {30'd0, state_out}, 32'd0);
    step(1, 32'h110, 32'h44, 1, 1, 0);
    step(1, 32'h110, 32'h44, 0, 0, 1);
    chk("flht_state", {30'd0, state_out}, 32'd0);
    chk("flht_bub", bubble_cnt, PERF ? 32'd3 : 32'd0);
    step(1, 32'h110, 32'h44, 0, 0, 0);
    chk("flht_load", instr_out, 32'h44);

    // reset in the middle of HOLD_TWO, then held
    step(1, 32'h114, 32'h55, 1, 1, 0);
    step(0, 32'h118, 32'h66, 1, 0, 1);
    chk("rht_pc", pc_out, 32'h0);
    chk("rht_pc4", pc4_out, 32'h4);
    chk("rht_instr", instr_out, 32'h0);
    chk("rht_state", {30'd0, state_out}, 32'd0);
    chk("rht_stall", stall_cnt, 32'd0);
    chk("rht_bub", bubble_cnt, 32'd0);
    step(0, 32'h11C, 32'h77, 0, 0, 0);
    chk("rhold_pc", pc_out, 32'h0);

    step(1, 32'hFFFF_FFFC, 32'h88, 0, 0, 0);
    chk("wrap_pc4", pc4_out, 32'h0);

    // short pseudo-random tail checked by the model
    for (int i = 0; i < 200; i++)
      step(1, $urandom, $urandom, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
